m_mem_unit: RTL and testbench

//  M-stage data-memory access unit: issues load/store requests on a req/ack data bus and stalls the pipeline

---
 rtl/m_mem_unit.sv | 218 +++++++++++++++++++++
 tb/tb_m_mem_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_mem_unit.sv
// ---------------------------------------------------------------------------
// m_mem_unit -- M-stage data-memory access unit.
//
// Issues one load/store per M instruction on a req/ack data bus and stalls
// the pipeline until the access completes. It produces byte enables and
// lane-replicated store data, and sign/zero-extends load data into DR_o.
// Misaligned addresses raise AdEL/AdES instead of touching the bus.
//
// Optional feature: define MEM_TIMEOUT_EN to enable a bus timeout. After
// TIMEOUT_CYCLES BUSY cycles with no ack, the access is abandoned and a DBE
// exception (code 7) is reported in DONE. When the macro is undefined, BUSY
// waits indefinitely for ack.
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous active-low reset
//   mem_op_i     in   4   0 none,1 lw,2 lh,3 lhu,4 lb,5 lbu,6 sw,7 sh,8 sb
//   mem_addr_i   in   32  byte address
//   mem_wdata_i  in   32  store data
//   flush_i      in   1   suppresses issue of the current M instruction
//   bus_req_o    out  1   request (registered)
//   bus_we_o     out  1   1 = store
//   bus_be_o     out  4   byte enables
//   bus_addr_o   out  32  word address
//   bus_wdata_o  out  32  lane-replicated store data
//   bus_ack_i    in   1   access complete; rdata valid the same cycle
//   bus_rdata_i  in   32  read word
//   stall_o      out  1   pipeline freeze
//   DR_o         out  32  extended load result (registered)
//   exc_o        out  1   exception from this stage
//   exc_code_o   out  5   4 AdEL, 5 AdES, 7 DBE
// ---------------------------------------------------------------------------
module m_mem_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic [31:0] DR_o,
  output logic        exc_o,
  output logic [4:0]  exc_code_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;

  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic        access;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             timeout_q;
`endif

  // Decode of the op currently presented in M.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = mem_wdata_i;
    case (mem_op_i)
      OP_LW:          begin is_load  = 1'b1; misaligned = |mem_addr_i[1:0]; end
      OP_LH, OP_LHU:  begin is_load  = 1'b1; misaligned = mem_addr_i[0];    end
      OP_LB, OP_LBU:  begin is_load  = 1'b1; end
      OP_SW:          begin is_store = 1'b1; misaligned = |mem_addr_i[1:0]; end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = mem_addr_i[0];
        be_next    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{mem_wdata_i[15:0]}};
      end
      OP_SB: begin
        is_store   = 1'b1;
        be_next    = 4'b0001 << mem_addr_i[1:0];
        wdata_next = {4{mem_wdata_i[7:0]}};
      end
      default: ;
    endcase
    access = (is_load || is_store) && !misaligned && !flush_i;
  end

  // Lane extraction uses the op and address latched at issue.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = bus_rdata_i[7:0];
      2'd1:    byte_sel = bus_rdata_i[15:8];
      2'd2:    byte_sel = bus_rdata_i[23:16];
      default: byte_sel = bus_rdata_i[31:24];
    endcase
    half_sel = lane_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (op_q)
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0000, half_sel};
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h000000, byte_sel};
      default: load_ext = bus_rdata_i;
    endcase
  end

  always_comb begin
    case (state)
      S_IDLE:  stall_o = access;
      S_BUSY:  stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  always_comb begin
    exc_o      = 1'b0;
    exc_code_o = 5'd0;
    if (state == S_IDLE && (is_load || is_store) && misaligned && !flush_i) begin
      exc_o      = 1'b1;
      exc_code_o = is_load ? 5'd4 : 5'd5;
    end
`ifdef MEM_TIMEOUT_EN
    if (state == S_DONE && timeout_q) begin
      exc_o      = 1'b1;
      exc_code_o = 5'd7;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      DR_o        <= '0;
      op_q        <= '0;
      lane_q      <= '0;
`ifdef MEM_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_be_o    <= be_next;
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_wdata_o <= wdata_next;
            op_q        <= mem_op_i;
            lane_q      <= mem_addr_i[1:0];
            state       <= S_BUSY;
`ifdef MEM_TIMEOUT_EN
            to_cnt      <= '0;
`endif
          end
        end
        S_BUSY: begin
          // flush_i is deliberately not looked at: an issued access always completes.
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (!bus_we_o) DR_o <= load_ext;
            state     <= S_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus_req_o <= 1'b0;
            DR_o      <= '0;
            timeout_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: begin
          // One non-stalled cycle lets the pipeline advance, so the op still in M is not re-issued.
          state <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_m_mem_unit -- directed self-checking bench for m_mem_unit.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_m_mem_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 256;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        flush;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] dr;
  logic        exc;
  logic [4:0]  exc_code;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] model_dr = 32'h0;

  m_mem_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_op_i    (mem_op),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .flush_i     (flush),
    .bus_req_o   (bus_req),
    .bus_we_o    (bus_we),
    .bus_be_o    (bus_be),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_ack_i   (bus_ack),
    .bus_rdata_i (bus_rdata),
    .stall_o     (stall),
    .DR_o        (dr),
    .exc_o       (exc),
    .exc_code_o  (exc_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Load with 'waits' wait cycles before ack; checks cycle counts and DR_o in DONE.
  task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input int unsigned waits,
                          input logic [31:0] exp_dr);
    int unsigned req_cyc = 0;
    int unsigned stall_cyc = 0;
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_wdata = 32'h0;
    #1;
    if (stall) stall_cyc++;
    if (bus_req) req_cyc++;
    for (int unsigned k = 0; k <= waits; k++) begin
      @(negedge clk);
      if (k == waits) begin bus_ack = 1'b1; bus_rdata = rdata; end
      #1;
      if (stall) stall_cyc++;
      if (bus_req) req_cyc++;
      if (k == 0) begin
        check({tag, " addr"}, bus_addr, {addr[31:2], 2'b00});
        check({tag, " be"}, 32'(bus_be), 32'hF);
        check({tag, " we"}, 32'(bus_we), 32'h0);
      end
    end
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h0; mem_op = 4'd0;
    #1;
    check({tag, " done req"}, 32'(bus_req), 32'h0);
    check({tag, " done stall"}, 32'(stall), 32'h0);
    check({tag, " dr"}, dr, exp_dr);
    model_dr = exp_dr;
    check({tag, " req cycles"}, req_cyc, waits + 1);
    check({tag, " stall cycles"}, stall_cyc, waits + 2);
    @(negedge clk); #1;
    check({tag, " idle req"}, 32'(bus_req), 32'h0);
  endtask

  task automatic run_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_wdata = wdata;
    #1;
    check({tag, " idle stall"}, 32'(stall), 32'h1);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h5555AAAA;
    #1;
    check({tag, " req"}, 32'(bus_req), 32'h1);
    check({tag, " we"}, 32'(bus_we), 32'h1);
    check({tag, " addr"}, bus_addr, exp_addr);
    check({tag, " be"}, 32'(bus_be), 32'(exp_be));
    check({tag, " wdata"}, bus_wdata, exp_wdata);
    @(negedge clk);
    bus_ack = 1'b0; mem_op = 4'd0;
    #1;
    check({tag, " done req"}, 32'(bus_req), 32'h0);
    check({tag, " dr kept"}, dr, model_dr);
    @(negedge clk);
  endtask

  task automatic run_misaligned(input string tag, input logic [3:0] op,
                                input logic [31:0] addr, input logic [4:0] exp_code);
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_wdata = 32'hFFFF_FFFF;
    #1;
    check({tag, " exc"}, 32'(exc), 32'h1);
    check({tag, " code"}, 32'(exc_code), 32'(exp_code));
    check({tag, " stall"}, 32'(stall), 32'h0);
    @(negedge clk);
    mem_op = 4'd0;
    #1;
    check({tag, " no req"}, 32'(bus_req), 32'h0);
    check({tag, " exc clr"}, 32'(exc), 32'h0);
  endtask

  initial begin
    reset = 1'b0; mem_op = 4'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
    flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    check("rst req", 32'(bus_req), 32'h0);
    check("rst we", 32'(bus_we), 32'h0);
    check("rst be", 32'(bus_be), 32'h0);
    check("rst addr", bus_addr, 32'h0);
    check("rst wdata", bus_wdata, 32'h0);
    check("rst dr", dr, 32'h0);
    check("rst exc", 32'(exc), 32'h0);
    check("rst code", 32'(exc_code), 32'h0);
    check("rst stall", 32'(stall), 32'h0);
    reset = 1'b1;

    run_load("lw wait2", 4'd1, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
    run_load("lb 103",   4'd4, 32'h0000_0103, 32'h80FF_FF7F, 0, 32'hFFFF_FF80);
    run_load("lbu 103",  4'd5, 32'h0000_0103, 32'h80FF_FF7F, 0, 32'h0000_0080);
    run_load("lh 102",   4'd2, 32'h0000_0102, 32'h80FF_FF7F, 0, 32'hFFFF_80FF);
    run_load("lhu 102",  4'd3, 32'h0000_0102, 32'h80FF_FF7F, 1, 32'h0000_80FF);
    run_load("lb 100",   4'd4, 32'h0000_0100, 32'h80FF_FF7F, 0, 32'h0000_007F);
    run_load("lh 100",   4'd2, 32'h0000_0100, 32'h1234_8001, 0, 32'hFFFF_8001);

    run_store("sb 201", 4'd8, 32'h0000_0201, 32'h0000_00AB, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB);
    run_store("sh 202", 4'd7, 32'h0000_0202, 32'h1234_CAFE, 32'h0000_0200, 4'b1100, 32'hCAFE_CAFE);
    run_store("sh 200", 4'd7, 32'h0000_0200, 32'h0000_BEEF, 32'h0000_0200, 4'b0011, 32'hBEEF_BEEF);
    run_store("sw 204", 4'd6, 32'h0000_0204, 32'h1122_3344, 32'h0000_0204, 4'b1111, 32'h1122_3344);
    run_store("sb 203", 4'd8, 32'h0000_0203, 32'h1234_56CD, 32'h0000_0200, 4'b1000, 32'hCDCD_CDCD);

    run_misaligned("lw 102", 4'd1, 32'h0000_0102, 5'd4);
    run_misaligned("sh 201", 4'd7, 32'h0000_0201, 5'd5);
    run_misaligned("lhu 101", 4'd3, 32'h0000_0101, 5'd4);
    run_misaligned("sw 203", 4'd6, 32'h0000_0203, 5'd5);

    // Reset during BUSY, then a stray ack must be ignored.
    @(negedge clk);
    mem_op = 4'd1; mem_addr = 32'h0000_0100;
    @(negedge clk);
    mem_op = 4'd0;
    #1;
    check("busy req", 32'(bus_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("midrst req", 32'(bus_req), 32'h0);
    check("midrst stall", 32'(stall), 32'h0);
    check("midrst dr", dr, 32'h0);
    model_dr = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    #1;
    check("stray ack req", 32'(bus_req), 32'h0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("stray ack dr", dr, 32'h0);
    check("stray ack stall", 32'(stall), 32'h0);

    // Flushed op in IDLE is not issued.
    @(negedge clk);
    mem_op = 4'd1; mem_addr = 32'h0000_0100; flush = 1'b1;
    #1;
    check("flush stall", 32'(stall), 32'h0);
    @(negedge clk); #1;
    check("flush req", 32'(bus_req), 32'h0);
    mem_op = 4'd0; flush = 1'b0;

`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    run_load("lw pre", 4'd1, 32'h0000_0300, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
    @(negedge clk);
    mem_op = 4'd1; mem_addr = 32'h0000_0300;
    for (int unsigned k = 0; k < TO; k++) begin
      @(negedge clk);
      mem_op = 4'd0;
      #1;
      check("to busy req", 32'(bus_req), 32'h1);
    end
    @(negedge clk); #1;
    check("to req", 32'(bus_req), 32'h0);
    check("to exc", 32'(exc), 32'h1);
    check("to code", 32'(exc_code), 32'h7);
    check("to dr", dr, 32'h0);
    check("to stall", 32'(stall), 32'h0);
    @(negedge clk); #1;
    check("to exc clr", 32'(exc), 32'h0);
`else
    run_load("lw wait9", 4'd1, 32'h0000_0300, 32'hCAFE_F00D, 9, 32'hCAFE_F00D);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
